// File: rtl/float_pkg.sv
// Shared floating-point format constants and the iterative multiplier state type.
package float_pkg;

    localparam int SP_FLOAT_SIZE    = 32;
    localparam int SP_EXPONENT_SIZE = 8;
    localparam int SP_MANTISSA_SIZE = 23;
    localparam int SP_BIAS          = 127;

    localparam int DP_FLOAT_SIZE    = 64;
    localparam int DP_EXPONENT_SIZE = 11;
    localparam int DP_MANTISSA_SIZE = 52;
    localparam int DP_BIAS          = 1023;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM,
        DONE
    } float_mul_state_t;

endpackage

// File: rtl/float_mantissa_mul_seq.sv
// Shift-add unsigned multiplier: one multiplier bit per clock, WIDTH iterations per product.
module float_mantissa_mul_seq #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            mcand_d  = (2*WIDTH)'(mcand);
            mplier_d = mplier;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    // done flags the cycle whose closing edge performs the final iteration.
    assign done    = busy_q && (cnt_q == LAST);
    assign product = prod_q;

endmodule

// File: rtl/float_multiplier_iterative.sv
// Sequential truncating float multiplier: shift-add mantissa engine plus exponent/sign path and handshakes.
module float_multiplier_iterative
    import float_pkg::*;
#(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);

    localparam int M  = MANTISSA_SIZE;
    localparam int W  = MANTISSA_SIZE + 1;
    localparam int EW = EXPONENT_SIZE + 2;

    float_mul_state_t state_q, state_d;

    logic                     sign_q, sign_d;
    logic [EXPONENT_SIZE-1:0] ea_q, ea_d;
    logic [EXPONENT_SIZE-1:0] eb_q, eb_d;
    logic [FLOAT_SIZE-1:0]    out_q, out_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;
    logic                     inexact_q, inexact_d;

    logic                     start;
    logic                     mul_done;
    logic [2*W-1:0]           prod;

    logic                     norm_n;
    logic [EW-1:0]            exp_sum;
    logic [M-1:0]             mant;
    logic                     lost_bits;

    assign start = (state_q == IDLE) && in_valid;

    float_mantissa_mul_seq #(
        .WIDTH(W)
    ) u_mant_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mcand   ({1'b1, a[M-1:0]}),
        .mplier  ({1'b1, b[M-1:0]}),
        .done    (mul_done),
        .product (prod)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            out_q       <= out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            inexact_q   <= inexact_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = MULT;
            MULT: if (mul_done) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Product of two values in [1,2) lies in [1,4); the top bit selects the normalizing shift.
    always_comb begin
        norm_n    = prod[2*W-1];
        exp_sum   = {2'b00, ea_q} + {2'b00, eb_q} - EW'(BIAS) + EW'(norm_n);
        mant      = norm_n ? prod[2*M:M+1] : prod[2*M-1:M];
        lost_bits = norm_n ? |prod[M:0] : |prod[M-1:0];
    end

    always_comb begin
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        out_d       = out_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        if (start) begin
            sign_d = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
            ea_d   = a[FLOAT_SIZE-2:M];
            eb_d   = b[FLOAT_SIZE-2:M];
        end
        if (state_q == NORM) begin
            out_d       = {sign_q, exp_sum[EXPONENT_SIZE-1:0], mant};
            underflow_d = exp_sum[EXPONENT_SIZE+1];
            overflow_d  = exp_sum[EXPONENT_SIZE] & ~exp_sum[EXPONENT_SIZE+1];
            inexact_d   = lost_bits;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out       = out_q;
        overflow  = overflow_q;
        underflow = underflow_q;
        inexact   = inexact_q;
    end

endmodule

// File: tb/tb_float_multiplier_iterative.sv
// Bench for float_multiplier_iterative: arithmetic reference model plus directed SP/DP vectors.
module tb_float_multiplier_iterative;
    import float_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, out;
    logic        ovf, unf, inx;

    logic        dp_in_valid, dp_in_ready, dp_out_valid, dp_out_ready;
    logic [63:0] dp_a, dp_b, dp_out;
    logic        dp_ovf, dp_unf, dp_inx;

    float_multiplier_iterative #(
        .FLOAT_SIZE(SP_FLOAT_SIZE), .EXPONENT_SIZE(SP_EXPONENT_SIZE),
        .MANTISSA_SIZE(SP_MANTISSA_SIZE), .BIAS(SP_BIAS)
    ) dut_sp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .overflow(ovf), .underflow(unf), .inexact(inx)
    );

    float_multiplier_iterative #(
        .FLOAT_SIZE(DP_FLOAT_SIZE), .EXPONENT_SIZE(DP_EXPONENT_SIZE),
        .MANTISSA_SIZE(DP_MANTISSA_SIZE), .BIAS(DP_BIAS)
    ) dut_dp (
        .clk(clk), .reset(reset), .in_valid(dp_in_valid), .in_ready(dp_in_ready),
        .a(dp_a), .b(dp_b), .out_valid(dp_out_valid), .out_ready(dp_out_ready), .out(dp_out),
        .overflow(dp_ovf), .underflow(dp_unf), .inexact(dp_inx)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic        exp_active = 1'b0;
    logic [63:0] exp_out;
    logic [2:0]  exp_flags;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Real-valued reasoning in integers: exact product, then truncate and classify the exponent.
    function automatic void model(input logic [63:0] av, input logic [63:0] bv,
                                  input int m, input int e, input int bias,
                                  output logic [63:0] res, output logic [2:0] flags);
        logic [127:0] ma, mb, p, mant, rem;
        int ea, eb, ex, n;
        logic s;
        ma = (128'(av) & ((128'(1) << m) - 1)) | (128'(1) << m);
        mb = (128'(bv) & ((128'(1) << m) - 1)) | (128'(1) << m);
        ea = int'((av >> m) & ((64'(1) << e) - 1));
        eb = int'((bv >> m) & ((64'(1) << e) - 1));
        s  = av[m+e] ^ bv[m+e];
        p  = ma * mb;
        n  = int'(p >> (2*m + 1));
        ex = ea + eb - bias + n;
        mant = (p >> (m + n)) & ((128'(1) << m) - 1);
        rem  = p & ((128'(1) << (m + n)) - 1);
        flags[2] = (ex >= 0) && (ex >= (1 << e));
        flags[1] = (ex < 0);
        flags[0] = (rem != 0);
        res = (64'(s) << (m + e)) | (64'(ex & ((1 << e) - 1)) << m) | mant[63:0];
    endfunction

    // Whenever the SP result is presented, it must equal the model for the accepted operands.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!exp_active) begin
                check("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                check("out_vs_model", 64'(out), exp_out);
                check("flags_vs_model", 64'({ovf, unf, inx}), 64'(exp_flags));
                check("in_ready_low_in_done", 64'(in_ready), 64'(0));
            end
        end
    end

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] lit_out, input logic [2:0] lit_flags,
                          input int hold);
        logic [63:0] r;
        logic [2:0]  f;
        int lat;
        model(64'(av), 64'(bv), SP_MANTISSA_SIZE, SP_EXPONENT_SIZE, SP_BIAS, r, f);
        check("model_pin_out", r, 64'(lit_out));
        check("model_pin_flags", 64'(f), 64'(lit_flags));
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        a = av; b = bv; in_valid = 1'b1;
        out_ready = (hold == 0);
        exp_out = r; exp_flags = f; exp_active = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("latency", 64'(lat), 64'(25));
        check("out_literal", 64'(out), 64'(lit_out));
        check("flags_literal", 64'({ovf, unf, inx}), 64'(lit_flags));
        if (hold > 0) begin
            a = 32'h40000000; b = 32'h40000000; in_valid = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                check("in_ready_hold", 64'(in_ready), 64'(0));
                check("out_valid_hold", 64'(out_valid), 64'(1));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_valid_after_take", 64'(out_valid), 64'(0));
        check("in_ready_after_take", 64'(in_ready), 64'(1));
        exp_active = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        logic [2:0]  f;
        int lat;

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        dp_in_valid = 1'b0; dp_out_ready = 1'b1; dp_a = '0; dp_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out", 64'(out), 64'(0));
        check("reset_flags", 64'({ovf, unf, inx}), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, 0);
        run_op(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 0);
        run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 0);
        run_op(32'h7F000000, 32'h7F000000, 32'h3E800000, 3'b100, 0);
        run_op(32'h00800000, 32'h00800000, 32'h41800000, 3'b010, 0);
        run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b001, 0);
        run_op(32'h40400000, 32'h40400000, 32'h41100000, 3'b000, 10);

        // Abort an operation part-way through the mantissa iterations.
        @(negedge clk);
        a = 32'h3FC00000; b = 32'h3FC00000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_out", 64'(out), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 0);

        model(64'h3FF0000000000000, 64'h3FF0000000000000,
              DP_MANTISSA_SIZE, DP_EXPONENT_SIZE, DP_BIAS, r, f);
        check("dp_model_pin", r, 64'h3FF0000000000000);
        @(negedge clk);
        dp_a = 64'h3FF0000000000000; dp_b = 64'h3FF0000000000000; dp_in_valid = 1'b1;
        @(posedge clk);
        #1 dp_in_valid = 1'b0;
        lat = 0;
        while (!dp_out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("dp_latency", 64'(lat), 64'(54));
        check("dp_out", dp_out, 64'h3FF0000000000000);
        check("dp_flags", 64'({dp_ovf, dp_unf, dp_inx}), 64'(0));
        @(posedge clk);
        #1;
        check("dp_in_ready_after_take", 64'(dp_in_ready), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
